// File: rtl/filler_sig_monitor_pkg.sv
// Shared definitions for the filler signature monitor: FSM encoding, default
// MISR polynomial and the default bus-to-signature fold ratio.
package filler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] DEFAULT_POLY      = 32'h04C11DB7;
  localparam int          DEFAULT_SIG_WIDTH = 32;
  localparam int          FOLD_RATIO        = 10;

endpackage

// File: rtl/filler_sig_monitor_misr_reg.sv
// Multiple-input signature register: shift left with polynomial feedback from
// the MSB, XOR in one folded word per enabled cycle. load takes priority.
module misr_reg
  import filler_pkg::*;
#(
  parameter int                   SIG_WIDTH = DEFAULT_SIG_WIDTH,
  parameter logic [SIG_WIDTH-1:0] POLY      = SIG_WIDTH'(DEFAULT_POLY)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [SIG_WIDTH-1:0] seed,
  input  logic                 en,
  input  logic [SIG_WIDTH-1:0] din,
  output logic [SIG_WIDTH-1:0] sig
);

  logic [SIG_WIDTH-1:0] sig_q;
  logic [SIG_WIDTH-1:0] sig_d;

  always_comb begin
    sig_d = {sig_q[SIG_WIDTH-2:0], 1'b0} ^ (sig_q[SIG_WIDTH-1] ? POLY : '0) ^ din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_q <= '0;
    end else if (load) begin
      sig_q <= seed;
    end else if (en) begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/filler_sig_monitor.sv
// Folds the filler output bus into a MISR signature over a programmable window
// so all filler logic stays observable and a bench gets one value per run.
module filler_sig_monitor
  import filler_pkg::*;
#(
  parameter int                   NOC_WIDTH = DEFAULT_SIG_WIDTH * FOLD_RATIO,
  parameter int                   SIG_WIDTH = DEFAULT_SIG_WIDTH,
  parameter int unsigned          WINDOW    = 1024,
  parameter logic [SIG_WIDTH-1:0] POLY      = SIG_WIDTH'(DEFAULT_POLY),
  parameter logic [SIG_WIDTH-1:0] SEED      = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clear,
  input  logic [NOC_WIDTH-1:0] data_in,
  output logic                 busy,
  output logic                 done,
  output logic [SIG_WIDTH-1:0] signature,
  output logic [15:0]          sample_count
);

  localparam int          RATIO    = NOC_WIDTH / SIG_WIDTH;
  localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);

  state_e               state_q, state_d;
  logic [15:0]          win_cnt_q, win_cnt_d;
  logic [NOC_WIDTH-1:0] d1_q;
  logic [SIG_WIDTH-1:0] fold_q, fold_d;
  logic                 en0, en1_q, en2_q;
  logic                 load;
  logic [15:0]          cnt_q;

  // Datapath is free-running; only en2 (aligned with fold) gates the MISR.
  always_comb begin
    fold_d = '0;
    for (int k = 0; k < RATIO; k++) begin
      fold_d = fold_d ^ d1_q[k*SIG_WIDTH +: SIG_WIDTH];
    end
  end

  assign en0 = (state_q == ST_RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d1_q   <= '0;
      fold_q <= '0;
      en1_q  <= 1'b0;
      en2_q  <= 1'b0;
    end else begin
      d1_q   <= data_in;
      fold_q <= fold_d;
      en1_q  <= clear ? 1'b0 : en0;
      en2_q  <= clear ? 1'b0 : en1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    load      = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d   = ST_RUN;
            win_cnt_d = '0;
            load      = 1'b1;
          end
        end
        ST_RUN: begin
          if (win_cnt_q == WIN_LAST) begin
            state_d   = ST_DRAIN;
            win_cnt_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 16'd1;
          end
        end
        ST_DRAIN: begin
          // Two cycles flush the en1/en2 pipeline before declaring done.
          if (win_cnt_q == 16'd1) begin
            state_d = ST_DONE;
          end else begin
            win_cnt_d = win_cnt_q + 16'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      win_cnt_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      if (load) begin
        cnt_q <= '0;
      end else if (en2_q) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  misr_reg #(
    .SIG_WIDTH(SIG_WIDTH),
    .POLY     (POLY)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .load(load),
    .seed(SEED),
    .en  (en2_q),
    .din (fold_q),
    .sig (signature)
  );

  assign busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done         = (state_q == ST_DONE);
  assign sample_count = cnt_q;

endmodule

// File: tb/tb_filler_sig_monitor.sv
// Bench for filler_sig_monitor: three instances (long random window, WINDOW=1,
// WINDOW=2 with MSB seed) checked against a word-level signature model.
module tb_filler_sig_monitor;

  localparam int          NOC_W  = 320;
  localparam int          SIG_W  = 32;
  localparam int          SLICES = NOC_W / SIG_W;
  localparam logic [31:0] POLY   = 32'h04C11DB7;
  localparam int          W_A    = 16;
  localparam logic [31:0] SEED_A = 32'hDEADBEEF;
  localparam int          W_B    = 1;
  localparam logic [31:0] SEED_B = 32'h0;
  localparam int          W_C    = 2;
  localparam logic [31:0] SEED_C = 32'h80000000;

  typedef struct packed {
    logic [1:0]  inst;
    logic [31:0] sig;
    logic [15:0] cnt;
    logic [31:0] done_cyc;
  } exp_t;

  exp_t             exp_q[$];
  logic [NOC_W-1:0] stream_q[$];

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [NOC_W-1:0] din [3];
  logic             st  [3];
  logic             cl  [3];
  logic             bz  [3];
  logic             dn  [3];
  logic [31:0]      sg  [3];
  logic [15:0]      sc  [3];

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  filler_sig_monitor #(.NOC_WIDTH(NOC_W), .SIG_WIDTH(SIG_W), .WINDOW(W_A), .POLY(POLY), .SEED(SEED_A))
    u_dut_a (.clk(clk), .rst(rst), .start(st[0]), .clear(cl[0]), .data_in(din[0]),
             .busy(bz[0]), .done(dn[0]), .signature(sg[0]), .sample_count(sc[0]));
  filler_sig_monitor #(.NOC_WIDTH(NOC_W), .SIG_WIDTH(SIG_W), .WINDOW(W_B), .POLY(POLY), .SEED(SEED_B))
    u_dut_b (.clk(clk), .rst(rst), .start(st[1]), .clear(cl[1]), .data_in(din[1]),
             .busy(bz[1]), .done(dn[1]), .signature(sg[1]), .sample_count(sc[1]));
  filler_sig_monitor #(.NOC_WIDTH(NOC_W), .SIG_WIDTH(SIG_W), .WINDOW(W_C), .POLY(POLY), .SEED(SEED_C))
    u_dut_c (.clk(clk), .rst(rst), .start(st[2]), .clear(cl[2]), .data_in(din[2]),
             .busy(bz[2]), .done(dn[2]), .signature(sg[2]), .sample_count(sc[2]));

  // reference model: signature of the first n words of stream_q from seed
  function automatic logic [31:0] model_sig(input logic [31:0] seed, input int n);
    logic [31:0] s;
    logic [31:0] f;
    logic [NOC_W-1:0] w;
    s = seed;
    for (int j = 0; j < n; j++) begin
      w = stream_q[j];
      f = '0;
      for (int k = 0; k < SLICES; k++) f = f ^ w[k*SIG_W +: SIG_W];
      s = {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
    end
    return s;
  endfunction

  function automatic logic [NOC_W-1:0] rand_word();
    logic [NOC_W-1:0] w;
    for (int k = 0; k < SLICES; k++) w[k*SIG_W +: SIG_W] = $urandom();
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // scoreboard monitor: pops one expectation per rising done
  task automatic monitor();
    logic prev [3];
    exp_t e;
    for (int i = 0; i < 3; i++) prev[i] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (dn[i] === 1'b1 && prev[i] !== 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done inst=%0d", i);
          end else begin
            e = exp_q.pop_front();
            check("done_inst", 64'(i), 64'(e.inst));
            check("signature", 64'(sg[i]), 64'(e.sig));
            check("sample_count", 64'(sc[i]), 64'(e.cnt));
            check("done_cycle", 64'(cyc), 64'(e.done_cyc));
            check("busy_in_done", 64'(bz[i]), 64'd0);
          end
        end
        prev[i] = dn[i];
      end
    end
  endtask

  task automatic wait_done(input int i, input int budget);
    int n;
    n = 0;
    while (dn[i] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (dn[i] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout inst=%0d actual=0 required=1", i);
    end
    @(negedge clk);
  endtask

  // driver: one full run on instance i
  task automatic do_run(input int i, input int w, input logic [31:0] seed,
                        input bit use_fixed, input logic [NOC_W-1:0] fixed, input bit mid_start);
    int   s_cyc;
    exp_t e;
    stream_q.delete();
    s_cyc = 0;
    @(negedge clk);
    st[i]  = 1'b1;
    din[i] = rand_word();
    for (int k = 1; k <= w; k++) begin
      @(negedge clk);
      if (k == 1) s_cyc = cyc;
      st[i]  = mid_start && (k == w / 2 + 1);
      din[i] = use_fixed ? fixed : rand_word();
      stream_q.push_back(din[i]);
    end
    @(negedge clk);
    st[i]      = 1'b0;
    din[i]     = rand_word();
    e.inst     = 2'(i);
    e.sig      = model_sig(seed, w);
    e.cnt      = 16'(w);
    e.done_cyc = 32'(s_cyc + w + 2);
    exp_q.push_back(e);
    wait_done(i, w + 10);
  endtask

  initial begin
    logic [31:0] part;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din[i] = '0;
      st[i]  = 1'b0;
      cl[i]  = 1'b0;
    end
    fork
      monitor();
    join_none
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bz[0]), 64'd0);
    check("reset_done", 64'(dn[0]), 64'd0);
    check("reset_signature", 64'(sg[0]), 64'd0);
    check("reset_count", 64'(sc[0]), 64'd0);
    rst = 1'b1;

    // random runs, back-to-back from DONE, one with start pulsed inside RUN
    do_run(0, W_A, SEED_A, 1'b0, '0, 1'b0);
    do_run(0, W_A, SEED_A, 1'b0, '0, 1'b1);
    do_run(0, W_A, SEED_A, 1'b0, '0, 1'b0);

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    st[0]  = 1'b1;
    din[0] = rand_word();
    repeat (6) begin
      @(negedge clk);
      st[0]  = 1'b0;
      din[0] = rand_word();
    end
    check("pre_reset_busy", 64'(bz[0]), 64'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_reset_busy", 64'(bz[0]), 64'd0);
    check("async_reset_done", 64'(dn[0]), 64'd0);
    check("async_reset_signature", 64'(sg[0]), 64'd0);
    check("async_reset_count", 64'(sc[0]), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    do_run(0, W_A, SEED_A, 1'b0, '0, 1'b0);

    // clear and start together after five samples: four reach the MISR
    stream_q.delete();
    @(negedge clk);
    st[0]  = 1'b1;
    din[0] = rand_word();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      st[0]  = 1'b0;
      din[0] = rand_word();
      stream_q.push_back(din[0]);
    end
    @(negedge clk);
    cl[0]  = 1'b1;
    st[0]  = 1'b1;
    din[0] = rand_word();
    @(negedge clk);
    cl[0] = 1'b0;
    st[0] = 1'b0;
    part  = model_sig(SEED_A, 4);
    check("clear_busy", 64'(bz[0]), 64'd0);
    check("clear_done", 64'(dn[0]), 64'd0);
    check("clear_count", 64'(sc[0]), 64'd4);
    check("clear_signature", 64'(sg[0]), 64'(part));
    repeat (3) @(negedge clk);
    check("clear_count_hold", 64'(sc[0]), 64'd4);
    check("clear_signature_hold", 64'(sg[0]), 64'(part));
    check("clear_stays_idle", 64'(bz[0]), 64'd0);
    do_run(0, W_A, SEED_A, 1'b0, '0, 1'b0);

    // WINDOW=1 directed and random
    do_run(1, W_B, SEED_B, 1'b1, {288'b0, 32'hA5A5A5A5}, 1'b0);
    check("single_slice_sig", 64'(sg[1]), 64'hA5A5A5A5);
    check("single_slice_count", 64'(sc[1]), 64'd1);
    do_run(1, W_B, SEED_B, 1'b1, {256'b0, 32'h1, 32'h1}, 1'b0);
    check("cancel_slices_sig", 64'(sg[1]), 64'h0);
    do_run(1, W_B, SEED_B, 1'b0, '0, 1'b0);
    do_run(1, W_B, SEED_B, 1'b0, '0, 1'b0);

    // WINDOW=2, MSB seed: feedback path
    do_run(2, W_C, SEED_C, 1'b1, '0, 1'b0);
    check("feedback_sig", 64'(sg[2]), 64'h09823B6E);
    do_run(2, W_C, SEED_C, 1'b1, {288'b0, 32'h1}, 1'b0);
    do_run(2, W_C, SEED_C, 1'b0, '0, 1'b0);

    repeat (4) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/filler_sig_monitor.md
Name: filler_sig_monitor

Overview:
- Downstream consumer of the filler block's NOC_WIDTH-bit output bus.
- Over a programmable window of cycles, folds each NOC_WIDTH word to SIG_WIDTH bits and compresses it into a MISR signature.
- Used in frequency-evaluation builds so that all filler logic stays observable and is not optimised away.
- Gives a bench a single comparable value per run.

Parameters:
- NOC_WIDTH, 320: input bus width; must be a multiple of SIG_WIDTH.
- SIG_WIDTH, 32: signature width.
- WINDOW, 1024: number of input cycles sampled per run; range 1..65535.
- POLY, 32'h04C11DB7: MISR feedback polynomial, SIG_WIDTH bits.
- SEED, 0: MISR value loaded at run start.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  pulse to begin a run.
- clear  input  1  synchronous abort back to IDLE.
- data_in  input  NOC_WIDTH  filler output bus.
- busy  output  1  high in RUN or DRAIN.
- done  output  1  high in DONE.
- signature  output  SIG_WIDTH  MISR value.
- sample_count  output  16  samples absorbed in the current or last run.

Behaviour:
- Reset (rst low, asynchronous): all registers cleared, FSM to IDLE.
  - busy=0, done=0, signature=0, sample_count=0.
  - SEED is not applied at reset.
- Datapath runs every cycle regardless of FSM state:
  - d1 <= data_in.
  - fold <= XOR of the NOC_WIDTH/SIG_WIDTH slices of d1. Slice k is d1[k*SIG_WIDTH +: SIG_WIDTH].
- Enable pipeline:
  - en0 = (state==RUN).
  - en1 <= en0; en2 <= en1, so en2 stays aligned with fold.
- MISR update when en2=1:
  - sig <= {sig[SIG_WIDTH-2:0],1'b0} ^ (sig[SIG_WIDTH-1] ? POLY : 0) ^ fold.
  - sample_count increments by 1 on each update.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: on start=1 -> RUN; load sig<=SEED, sample_count<=0, window counter<=0.
  - RUN: counter increments each cycle. When counter==WINDOW-1 -> DRAIN.
  - RUN samples exactly WINDOW consecutive data_in cycles. start is ignored.
  - DRAIN: lasts exactly 2 cycles to flush en1/en2, then -> DONE.
  - DONE: done=1; signature and sample_count are held. start=1 -> RUN with the same reloads as from IDLE.
- Timing: start sampled high at edge of cycle T.
  - data_in is sampled in cycles T+1 .. T+WINDOW.
  - The last MISR update occurs at the end of cycle T+WINDOW+2.
  - done=1 from cycle T+WINDOW+3.
- clear=1 in any state -> IDLE next cycle.
  - en1/en2 are zeroed, so no further MISR updates.
  - signature and sample_count hold their partial values. done=0, busy=0.
  - clear has priority over start in the same cycle.
- signature output is driven directly from sig; it is valid only while done=1.
- WINDOW=1: RUN lasts one cycle; behaviour otherwise unchanged.
- The window counter width is 16 bits; there is no wrap within a run.

Decomposition:
- Shared package `filler_pkg` holds:
  - FSM state encoding (2-bit enum: IDLE, RUN, DRAIN, DONE).
  - Default POLY constant.
  - A fold-ratio localparam, NOC_WIDTH/SIG_WIDTH.
- One natural sub-module: `misr_reg` (SIG_WIDTH, POLY).
  - Inputs: clk, rst, load, seed, en, din.
  - Output: sig.
- The fold stage and FSM stay in the top module.

Test Plan:
- Reset mid-run: assert rst low asynchronously while in RUN.
  - busy, done, signature and sample_count read 0 immediately, without a clock edge.
  - Release rst, pulse start -> a normal run completes.
- Single-slice data: WINDOW=1, SEED=0, data_in = slice0 32'hA5A5A5A5, all other slices 0.
  - signature=32'hA5A5A5A5, sample_count=1.
  - done rises exactly 4 cycles after the start edge.
- Shift check: WINDOW=2, SEED=0, data_in constant with slice0=32'h1.
  - signature=32'h3, sample_count=2.
  - slices 0 and 1 both 32'h1 -> fold=0 -> signature=0.
- Feedback: WINDOW=2, SEED=32'h80000000, data_in=0.
  - Update 1: signature=POLY=32'h04C11DB7.
  - Update 2: final signature=32'h09823B6E.
- Clear/start collision: assert clear and start together in RUN at sample 5 of 1024.
  - State goes to IDLE; sample_count holds 5±pipeline; done=0, busy=0.
  - A subsequent start restarts from SEED with sample_count=0.
- Back-to-back runs: start pulsed in DONE; start also pulsed during RUN.
  - start in RUN is ignored.
  - start in DONE begins a new WINDOW; the signature matches the reference model for the second data stream only.
